// File: rtl/tick_timer.sv
// tick_timer: programmable down-count timer advanced by a prescaler tick.
// Supports one-shot and periodic (auto-reload) operation. Command priority
// per cycle is stop > start > tick. expire and start_err are registered
// single-cycle pulses.
module tick_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         busy,
    output logic         expire,
    output logic         start_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] cnt_nx;
    logic [W-1:0] reload;
    logic [W-1:0] reload_nx;
    logic         mode;
    logic         mode_nx;
    logic         expire_nx;
    logic         start_err_nx;
    logic         load_ok;
    logic         last_tick;

    // Decode of the start operand and of the tick that completes an interval
    always_comb begin
        load_ok   = (load_val != '0);
        last_tick = (state == RUN) && tick && (cnt == W'(1));
    end

    // State, count, reload value, mode and the registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            reload    <= '0;
            mode      <= 1'b0;
            expire    <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            reload    <= reload_nx;
            mode      <= mode_nx;
            expire    <= expire_nx;
            start_err <= start_err_nx;
        end
    end

    // Next-state and datapath: stop beats start beats tick. A rejected start
    // (load_val==0) leaves the timer untouched, so a tick in that same cycle
    // is still counted by a running timer.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        reload_nx    = reload;
        mode_nx      = mode;
        expire_nx    = 1'b0;
        start_err_nx = 1'b0;
        if (stop) begin
            state_nx = IDLE;
        end else if (start && load_ok) begin
            cnt_nx    = load_val;
            reload_nx = load_val;
            mode_nx   = periodic;
            state_nx  = RUN;
        end else begin
            if (start) begin
                start_err_nx = 1'b1;
            end
            if (last_tick) begin
                expire_nx = 1'b1;
                if (mode) begin
                    cnt_nx = reload;
                end else begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end else if ((state == RUN) && tick && (cnt != '0)) begin
                cnt_nx = cnt - W'(1);
            end
        end
    end

    // Outputs derived from state
    always_comb begin
        busy = (state == RUN);
    end

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: randomized and directed stimulus for tick_timer, checked
// per cycle through a scoreboard queue fed by a ticks-remaining reference model.
module tb_tick_timer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         tick;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt;
    logic         busy;
    logic         expire;
    logic         start_err;

    typedef struct {
        int unsigned cnt;
        bit          busy;
        bit          expire;
        bit          start_err;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining ticks, running flag, interval, mode
    int unsigned m_left;
    int unsigned m_interval;
    bit          m_running;
    bit          m_periodic;

    tick_timer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .load_val  (load_val),
        .cnt       (cnt),
        .busy      (busy),
        .expire    (expire),
        .start_err (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_left     = 0;
        m_interval = 0;
        m_running  = 1'b0;
        m_periodic = 1'b0;
    endtask

    // Apply one cycle of commands to the model and queue the expected outputs
    // seen after the next rising edge. Drives inputs at a falling edge.
    task automatic step(input bit st, input bit sp, input bit tk, input bit per,
                        input int unsigned lv);
        exp_t e;
        start    = st;
        stop     = sp;
        tick     = tk;
        periodic = per;
        load_val = W'(lv);
        e.expire    = 1'b0;
        e.start_err = 1'b0;
        if (sp) begin
            m_running = 1'b0;
        end else if (st && lv != 0) begin
            m_left     = lv;
            m_interval = lv;
            m_periodic = per;
            m_running  = 1'b1;
        end else begin
            if (st) e.start_err = 1'b1;
            if (m_running && tk && m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    e.expire = 1'b1;
                    if (m_periodic) m_left = m_interval;
                    else m_running = 1'b0;
                end
            end
        end
        e.cnt  = m_left;
        e.busy = m_running;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n, input bit tk);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, tk, 1'b0, 0);
    endtask

    // Monitor: compares DUT outputs after every rising edge that has a queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("cnt", cnt, e.cnt);
                check("busy", busy, e.busy);
                check("expire", expire, e.expire);
                check("start_err", start_err, e.start_err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        tick     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        load_val = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_cnt", cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_expire", expire, 0);
        check("reset_start_err", start_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // One-shot, load 3, tick every 4th cycle
        step(1, 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            idle(3, 0);
            step(0, 0, 1, 0, 0);
        end
        idle(3, 1);

        // Periodic, load 2, tick every cycle for 10 ticks
        step(1, 0, 0, 1, 2);
        idle(10, 1);
        step(0, 1, 0, 0, 0);

        // stop and tick together at cnt==1
        step(1, 0, 0, 0, 2);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        idle(2, 1);

        // start with a tick in the same cycle
        step(1, 0, 1, 0, 7);
        idle(2, 0);
        step(0, 1, 0, 0, 0);

        // Rejected start in IDLE
        step(1, 0, 0, 0, 0);
        idle(2, 0);

        // Re-arm mid-run, then rejected start mid-run
        step(1, 0, 0, 0, 6);
        idle(2, 1);
        step(1, 0, 0, 0, 9);
        step(1, 0, 0, 1, 0);
        idle(3, 1);
        step(0, 1, 0, 0, 0);

        // Full-scale periodic interval, two reloads
        step(1, 0, 0, 1, 15);
        idle(32, 1);
        step(0, 1, 0, 0, 0);

        // Asynchronous reset mid-run with cnt==5
        step(1, 0, 0, 0, 5);
        idle(1, 0);
        start = 1'b0; stop = 1'b0; tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", cnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_expire", expire, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(8, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          st;
            bit          sp;
            bit          tk;
            bit          per;
            int unsigned lv;
            st  = ($urandom_range(0, 14) == 0);
            sp  = ($urandom_range(0, 59) == 0);
            tk  = ((i / 200) % 2 == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            per = $urandom_range(0, 1);
            lv  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
            step(st, sp, tk, per, lv);
        end

        idle(2, 0);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
